// File: rtl/flash_resp_pkg.sv
// rtl/flash_resp_pkg.sv - shared types for the flash write responder (erase field under FLASH_SECTOR_ERASE_EN)
package flash_resp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    ERASE = 2'd2,
    CHECK = 2'd3
  } state_t;

  typedef struct packed {
    logic [26:0] addr;
    logic [7:0]  data;
`ifdef FLASH_SECTOR_ERASE_EN
    logic        erase;
`endif
  } fresp_entry_t;

  localparam logic [7:0] FLASH_ERASE_BYTE = 8'hFF;

endpackage

// File: rtl/flash_req_fifo.sv
// rtl/flash_req_fifo.sv - request queue with registered full/empty flags (entry layout follows FLASH_SECTOR_ERASE_EN)
module flash_req_fifo
  import flash_resp_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  fresp_entry_t din,
  output fresp_entry_t dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  fresp_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [AW:0]   count_nxt;
  logic          push_ok;
  logic          pop_ok;

  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // Occupancy after this cycle's accepted push/pop; a simultaneous pair leaves it unchanged
  always_comb begin
    count_nxt = count;
    if (push_ok && !pop_ok) begin
      count_nxt = count + CNT_ONE;
    end else if (!push_ok && pop_ok) begin
      count_nxt = count - CNT_ONE;
    end
  end

  // Pointers, count and flags; flags come from the next count so they never depend combinationally on push
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      count <= count_nxt;
      full  <= (count_nxt == FULL_CNT);
      empty <= (count_nxt == '0);
    end
  end

  // Entry storage; contents need no reset because empty gates every read
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= din;
    end
  end

endmodule

// File: rtl/flash_write_responder.sv
// rtl/flash_write_responder.sv - queues flash program requests and commits them to SDRAM (sector erase under FLASH_SECTOR_ERASE_EN)
module flash_write_responder
  import flash_resp_pkg::*;
#(
`ifdef FLASH_SECTOR_ERASE_EN
  parameter int SECTOR_SIZE = 65536,
`endif
  parameter int DEPTH = 4
) (
  input  logic        clk21m,
  input  logic        reset_n,
  input  logic [26:0] flash_addr,
  input  logic [7:0]  flash_din,
  input  logic        flash_req,
`ifdef FLASH_SECTOR_ERASE_EN
  input  logic        flash_erase,
`endif
  output logic        flash_ready,
  output logic        flash_done,
  output logic        overflow,
  output logic [26:0] mem_addr,
  output logic [7:0]  mem_din,
  output logic        mem_we,
  input  logic        mem_ack
);

  state_t       state;
  state_t       state_nxt;
  fresp_entry_t push_entry;
  fresp_entry_t head;
  logic         fifo_full;
  logic         fifo_empty;
  logic         push;
  logic         pop;
  logic [26:0]  work_addr;
  logic [7:0]   work_data;

`ifdef FLASH_SECTOR_ERASE_EN
  localparam int SB = $clog2(SECTOR_SIZE);
  localparam logic [SB-1:0] CNT_ONE = SB'(1);
  logic          work_erase;
  logic [SB-1:0] cnt;
`endif

  assign flash_ready = ~fifo_full;
  assign push        = flash_req & flash_ready;
  assign pop         = (state == IDLE) & ~fifo_empty;

  // Pack the incoming request into a queue entry
  always_comb begin
    push_entry       = '0;
    push_entry.addr  = flash_addr;
    push_entry.data  = flash_din;
`ifdef FLASH_SECTOR_ERASE_EN
    push_entry.erase = flash_erase;
`endif
  end

  flash_req_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk21m),
    .rst_n (reset_n),
    .push  (push),
    .pop   (pop),
    .din   (push_entry),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // A request arriving while the queue is full is lost; remember that until reset
  always_ff @(posedge clk21m or negedge reset_n) begin
    if (!reset_n) begin
      overflow <= 1'b0;
    end else if (flash_req && !flash_ready) begin
      overflow <= 1'b1;
    end
  end

  // Latch the popped head as the job currently being committed
  always_ff @(posedge clk21m or negedge reset_n) begin
    if (!reset_n) begin
      work_addr <= '0;
      work_data <= '0;
`ifdef FLASH_SECTOR_ERASE_EN
      work_erase <= 1'b0;
`endif
    end else if (pop) begin
      work_addr <= head.addr;
      work_data <= head.data;
`ifdef FLASH_SECTOR_ERASE_EN
      work_erase <= head.erase;
`endif
    end
  end

`ifdef FLASH_SECTOR_ERASE_EN
  // Byte index within the sector being erased; restarts for every new job
  always_ff @(posedge clk21m or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (pop) begin
      cnt <= '0;
    end else if (state == ERASE && mem_ack) begin
      cnt <= cnt + CNT_ONE;
    end
  end
`endif

  // State register; reset drops mem_we at once because it decodes straight from state
  always_ff @(posedge clk21m or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: pop into WRITE/ERASE, hold until acked, then a one-cycle CHECK
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
`ifdef FLASH_SECTOR_ERASE_EN
          state_nxt = head.erase ? ERASE : WRITE;
`else
          state_nxt = WRITE;
`endif
        end
      end
      WRITE: begin
        if (mem_ack) begin
          state_nxt = CHECK;
        end
      end
`ifdef FLASH_SECTOR_ERASE_EN
      ERASE: begin
        if (mem_ack && (cnt == '1)) begin
          state_nxt = CHECK;
        end
      end
`endif
      CHECK:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs: memory port driven only while a write is outstanding, done only when nothing is left
  always_comb begin
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_din    = '0;
    flash_done = 1'b0;
    case (state)
      WRITE: begin
        mem_we   = 1'b1;
        mem_addr = work_addr;
        mem_din  = work_data;
      end
`ifdef FLASH_SECTOR_ERASE_EN
      ERASE: begin
        mem_we   = work_erase;
        mem_addr = {work_addr[26:SB], cnt};
        mem_din  = FLASH_ERASE_BYTE;
      end
`endif
      CHECK: flash_done = fifo_empty;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_flash_write_responder.sv
// tb/tb_flash_write_responder.sv - self-checking bench for flash_write_responder (erase cases under FLASH_SECTOR_ERASE_EN)
`timescale 1ns/1ps
module tb_flash_write_responder;

  localparam int DEPTH  = 4;
  localparam int SECTOR = 16;

  typedef struct {
    logic [26:0] addr;
    logic [7:0]  data;
  } wr_t;

  logic        clk21m = 1'b0;
  logic        reset_n = 1'b0;
  logic [26:0] flash_addr = '0;
  logic [7:0]  flash_din = '0;
  logic        flash_req = 1'b0;
`ifdef FLASH_SECTOR_ERASE_EN
  logic        flash_erase = 1'b0;
`endif
  logic        flash_ready;
  logic        flash_done;
  logic        overflow;
  logic [26:0] mem_addr;
  logic [7:0]  mem_din;
  logic        mem_we;
  logic        mem_ack = 1'b0;

  int     checks = 0;
  int     failures = 0;
  int     done_cnt = 0;
  int     commit_cnt = 0;
  longint cyc_no = 0;
  longint last_commit = -1;
  longint last_done = -1;
  bit     arb_on = 1'b0;
  wr_t    exp_q[$];

  flash_write_responder #(
`ifdef FLASH_SECTOR_ERASE_EN
    .SECTOR_SIZE (SECTOR),
`endif
    .DEPTH       (DEPTH)
  ) dut (
    .clk21m      (clk21m),
    .reset_n     (reset_n),
    .flash_addr  (flash_addr),
    .flash_din   (flash_din),
    .flash_req   (flash_req),
`ifdef FLASH_SECTOR_ERASE_EN
    .flash_erase (flash_erase),
`endif
    .flash_ready (flash_ready),
    .flash_done  (flash_done),
    .overflow    (overflow),
    .mem_addr    (mem_addr),
    .mem_din     (mem_din),
    .mem_we      (mem_we),
    .mem_ack     (mem_ack)
  );

  always #5 clk21m = ~clk21m;

  always @(posedge clk21m) cyc_no++;

  // Random arbiter: acknowledges outstanding writes after a random wait
  always begin
    @(negedge clk21m);
    if (arb_on) mem_ack = mem_we && ($urandom_range(0, 2) == 0);
  end

  // Monitor just before each rising edge: committed writes vs. expected order, hold stability, done legality
  logic [26:0] prev_addr = '0;
  logic [7:0]  prev_din = '0;
  bit          prev_hold = 1'b0;
  always begin : monitor
    wr_t e;
    @(negedge clk21m);
    #4;
    if (mem_we && prev_hold) begin
      checks++;
      if (mem_addr !== prev_addr || mem_din !== prev_din) begin
        failures++;
        $display("FAIL hold_stable: addr=%h din=%h required addr=%h din=%h", mem_addr, mem_din, prev_addr, prev_din);
      end
    end
    if (mem_we && mem_ack) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL commit_unexpected: addr=%h din=%h required no write", mem_addr, mem_din);
      end else begin
        e = exp_q.pop_front();
        if (mem_addr !== e.addr || mem_din !== e.data) begin
          failures++;
          $display("FAIL commit_data: addr=%h din=%h required addr=%h din=%h", mem_addr, mem_din, e.addr, e.data);
        end
      end
      commit_cnt++;
      last_commit = cyc_no;
    end
    prev_hold = mem_we && !mem_ack;
    prev_addr = mem_addr;
    prev_din  = mem_din;
    if (flash_done) begin
      done_cnt++;
      last_done = cyc_no;
      checks++;
      if (exp_q.size() != 0) begin
        failures++;
        $display("FAIL done_early: pending=%0d required 0", exp_q.size());
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected SDRAM writes for one accepted request; an erase covers its whole aligned sector with 8'hFF
  task automatic add_expected(input logic [26:0] a, input logic [7:0] d, input bit e);
    wr_t w;
    if (e) begin
      for (int k = 0; k < SECTOR; k++) begin
        w.addr = 27'((a / SECTOR) * SECTOR + k);
        w.data = 8'hFF;
        exp_q.push_back(w);
      end
    end else begin
      w.addr = a;
      w.data = d;
      exp_q.push_back(w);
    end
  endtask

  // One clock cycle of stimulus, driven at the falling edge; returns after the rising edge
  task automatic cyc(input bit r, input logic [26:0] a, input logic [7:0] d, input bit e, input bit ack, output bit acc);
    @(negedge clk21m);
    flash_req  = r;
    flash_addr = a;
    flash_din  = d;
`ifdef FLASH_SECTOR_ERASE_EN
    flash_erase = e;
`endif
    if (!arb_on) mem_ack = ack;
    acc = r && flash_ready && reset_n;
    @(posedge clk21m);
    if (acc) add_expected(a, d, e);
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) cyc(1'b0, '0, '0, 1'b0, 1'b0, acc);
  endtask

  task automatic wait_drain(input int limit);
    int n = 0;
    idle(1);
    while (exp_q.size() != 0 && n < limit) begin
      @(posedge clk21m);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout: pending=%0d required 0", exp_q.size());
    end
    idle(4);
  endtask

  task automatic arb_off();
    arb_on = 1'b0;
    @(negedge clk21m);
    mem_ack = 1'b0;
  endtask

  task automatic test_reset();
    logic [38:0] obs;
    logic [38:0] req;
    req = {1'b1, 1'b0, 1'b0, 1'b0, 27'h0, 8'h0};
    repeat (2) @(posedge clk21m);
    #1;
    obs = {flash_ready, flash_done, overflow, mem_we, mem_addr, mem_din};
    checks++;
    if (obs !== req) begin
      failures++;
      $display("FAIL reset_held: outputs=%h required %h", obs, req);
    end
    @(negedge clk21m);
    reset_n = 1'b1;
    @(posedge clk21m);
    #1;
    obs = {flash_ready, flash_done, overflow, mem_we, mem_addr, mem_din};
    checks++;
    if (obs !== req) begin
      failures++;
      $display("FAIL reset_released: outputs=%h required %h", obs, req);
    end
  endtask

  task automatic test_single_write();
    bit acc;
    int d0 = done_cnt;
    cyc(1'b1, 27'h0010000, 8'hA5, 1'b0, 1'b0, acc);
    #1;
    checks++;
    if (mem_we !== 1'b0) begin
      failures++;
      $display("FAIL single_latency1: mem_we=%b required 0", mem_we);
    end
    cyc(1'b0, '0, '0, 1'b0, 1'b0, acc);
    #1;
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== 27'h0010000 || mem_din !== 8'hA5) begin
      failures++;
      $display("FAIL single_write: we=%b addr=%h din=%h required we=1 addr=0010000 din=a5", mem_we, mem_addr, mem_din);
    end
    idle(3);
    cyc(1'b0, '0, '0, 1'b0, 1'b1, acc);
    #1;
    checks++;
    if (mem_we !== 1'b0 || flash_done !== 1'b1) begin
      failures++;
      $display("FAIL single_done: we=%b done=%b required we=0 done=1", mem_we, flash_done);
    end
    cyc(1'b0, '0, '0, 1'b0, 1'b0, acc);
    #1;
    checks++;
    if (flash_done !== 1'b0 || done_cnt - d0 != 1) begin
      failures++;
      $display("FAIL single_done_pulse: done=%b pulses=%0d required done=0 pulses=1", flash_done, done_cnt - d0);
    end
  endtask

  task automatic test_burst();
    bit acc;
    int n = 0;
    int d0;
    int c0 = commit_cnt;
    for (int i = 0; i < DEPTH + 1; i++) begin
      cyc(1'b1, 27'($urandom), 8'($urandom), 1'b0, 1'b0, acc);
      if (acc) n++;
    end
    #1;
    checks++;
    if (n != DEPTH + 1 || flash_ready !== 1'b0 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL burst_fill: accepted=%0d ready=%b overflow=%b required accepted=%0d ready=0 overflow=0", n, flash_ready, overflow, DEPTH + 1);
    end
    cyc(1'b1, 27'($urandom), 8'($urandom), 1'b0, 1'b0, acc);
    #1;
    checks++;
    if (acc || overflow !== 1'b1) begin
      failures++;
      $display("FAIL burst_overflow: accepted=%0d overflow=%b required accepted=0 overflow=1", acc, overflow);
    end
    d0 = done_cnt;
    arb_on = 1'b1;
    wait_drain(400);
    checks++;
    if (done_cnt - d0 != 1 || commit_cnt - c0 != DEPTH + 1 || overflow !== 1'b1) begin
      failures++;
      $display("FAIL burst_drain: pulses=%0d writes=%0d overflow=%b required pulses=1 writes=%0d overflow=1", done_cnt - d0, commit_cnt - c0, overflow, DEPTH + 1);
    end
    arb_off();
  endtask

  task automatic test_push_pop_full();
    bit acc;
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, 27'($urandom), 8'($urandom), 1'b0, 1'b0, acc);
    idle(3);
    #1;
    checks++;
    if (flash_ready !== 1'b1 || mem_we !== 1'b1) begin
      failures++;
      $display("FAIL pp_setup: ready=%b we=%b required ready=1 we=1", flash_ready, mem_we);
    end
    cyc(1'b0, '0, '0, 1'b0, 1'b1, acc);
    #1;
    checks++;
    if (flash_done !== 1'b0) begin
      failures++;
      $display("FAIL pp_no_done: done=%b required 0", flash_done);
    end
    cyc(1'b0, '0, '0, 1'b0, 1'b0, acc);
    cyc(1'b1, 27'($urandom), 8'($urandom), 1'b0, 1'b0, acc);
    #1;
    checks++;
    if (flash_ready !== 1'b1) begin
      failures++;
      $display("FAIL pp_ready_kept: ready=%b required 1", flash_ready);
    end
    cyc(1'b1, 27'($urandom), 8'($urandom), 1'b0, 1'b0, acc);
    #1;
    checks++;
    if (flash_ready !== 1'b0) begin
      failures++;
      $display("FAIL pp_count_full: ready=%b required 0", flash_ready);
    end
    arb_on = 1'b1;
    wait_drain(400);
    arb_off();
  endtask

  task automatic test_spurious_ack();
    bit acc;
    logic [26:0] a;
    int d0 = done_cnt;
    for (int i = 0; i < 3; i++) cyc(1'b0, '0, '0, 1'b0, 1'b1, acc);
    cyc(1'b0, '0, '0, 1'b0, 1'b0, acc);
    #1;
    checks++;
    if (mem_we !== 1'b0 || flash_ready !== 1'b1 || done_cnt != d0) begin
      failures++;
      $display("FAIL spurious_ack: we=%b ready=%b pulses=%0d required we=0 ready=1 pulses=0", mem_we, flash_ready, done_cnt - d0);
    end
    a = 27'($urandom);
    cyc(1'b1, a, 8'h3C, 1'b0, 1'b0, acc);
    cyc(1'b0, '0, '0, 1'b0, 1'b0, acc);
    #1;
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== a || mem_din !== 8'h3C) begin
      failures++;
      $display("FAIL spurious_next: we=%b addr=%h din=%h required we=1 addr=%h din=3c", mem_we, mem_addr, mem_din, a);
    end
    arb_on = 1'b1;
    wait_drain(400);
    arb_off();
  endtask

  task automatic test_reset_mid();
    bit acc;
    int d0;
    int c0;
    for (int i = 0; i < 3; i++) cyc(1'b1, 27'($urandom), 8'($urandom), 1'b0, 1'b0, acc);
    idle(2);
    #1;
    checks++;
    if (mem_we !== 1'b1 || overflow !== 1'b1) begin
      failures++;
      $display("FAIL rst_setup: we=%b overflow=%b required we=1 overflow=1", mem_we, overflow);
    end
    d0 = done_cnt;
    c0 = commit_cnt;
    @(negedge clk21m);
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    checks++;
    if (mem_we !== 1'b0 || flash_ready !== 1'b1 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL rst_async: we=%b ready=%b overflow=%b required we=0 ready=1 overflow=0", mem_we, flash_ready, overflow);
    end
    repeat (3) @(posedge clk21m);
    @(negedge clk21m);
    reset_n = 1'b1;
    idle(5);
    #1;
    checks++;
    if (mem_we !== 1'b0 || done_cnt != d0 || commit_cnt != c0) begin
      failures++;
      $display("FAIL rst_discard: we=%b pulses=%0d writes=%0d required we=0 pulses=0 writes=0", mem_we, done_cnt - d0, commit_cnt - c0);
    end
    arb_on = 1'b1;
    cyc(1'b1, 27'($urandom), 8'($urandom), 1'b0, 1'b0, acc);
    wait_drain(400);
    checks++;
    if (done_cnt - d0 != 1 || commit_cnt - c0 != 1) begin
      failures++;
      $display("FAIL rst_resume: pulses=%0d writes=%0d required pulses=1 writes=1", done_cnt - d0, commit_cnt - c0);
    end
    arb_off();
  endtask

`ifdef FLASH_SECTOR_ERASE_EN
  task automatic test_erase();
    bit acc;
    int d0 = done_cnt;
    int c0 = commit_cnt;
    arb_on = 1'b1;
    cyc(1'b1, 27'h0000123, 8'($urandom), 1'b1, 1'b0, acc);
    wait_drain(800);
    checks++;
    if (done_cnt - d0 != 1 || commit_cnt - c0 != SECTOR) begin
      failures++;
      $display("FAIL erase_sector: pulses=%0d writes=%0d required pulses=1 writes=%0d", done_cnt - d0, commit_cnt - c0, SECTOR);
    end
    arb_off();
  endtask
`endif

  task automatic test_random();
    bit acc;
    bit e;
    arb_on = 1'b1;
    for (int i = 0; i < 300; i++) begin
      e = 1'b0;
`ifdef FLASH_SECTOR_ERASE_EN
      e = ($urandom_range(0, 15) == 0);
`endif
      cyc(($urandom_range(0, 2) == 0) && flash_ready, 27'($urandom), 8'($urandom), e, 1'b0, acc);
    end
    wait_drain(4000);
    checks++;
    if (last_done <= last_commit) begin
      failures++;
      $display("FAIL random_final_done: last_done=%0d required after last write %0d", last_done, last_commit);
    end
    arb_off();
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_burst();
    test_push_pop_full();
    test_spurious_ack();
    test_reset_mid();
`ifdef FLASH_SECTOR_ERASE_EN
    test_erase();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
